// File: rtl/mppt_po_controller_pkg.sv
// mppt_po_controller_pkg: shared FSM state encoding, default duty/step constants
// and the ADC sample clamp used by the perturb-and-observe MPPT controller.
package mppt_po_controller_pkg;

    typedef enum logic [2:0] {
        IDLE, REQ_V, WAIT_V, REQ_I, WAIT_I, CALC, UPDATE, SETTLE
    } state_e;

    localparam int DUTY_W_DEF    = 10;
    localparam int DUTY_INIT_DEF = 512;
    localparam int DUTY_MIN_DEF  = 64;
    localparam int DUTY_MAX_DEF  = 960;
    localparam int STEP_DEF      = 4;

    // Negative readings carry no power information, so they count as zero.
    function automatic logic [14:0] clamp_sample(input logic [15:0] s);
        return s[15] ? 15'd0 : s[14:0];
    endfunction

endpackage

// File: rtl/mppt_po_controller_pwm_gen.sv
// pwm_gen: free-running PWM with a shadow duty register reloaded only at the wrap.
// Ports: clk, rst_n (async active-low), duty_i (committed duty), pwm_o (gate drive).
module pwm_gen
    import mppt_po_controller_pkg::*;
#(
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int DUTY_INIT = DUTY_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              pwm_o
);

    logic [DUTY_W-1:0] cnt_q, cnt_d, act_q, act_d;
    logic              pwm_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        act_d = (&cnt_q) ? duty_i : act_q;
    end

    // pwm_q is computed from the next counter/active values so it lines up
    // with the counter it describes while still resetting to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            act_q <= DUTY_W'(DUTY_INIT);
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            act_q <= act_d;
            pwm_q <= cnt_d < act_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/mppt_po_controller.sv
// mppt_po_controller: perturb-and-observe MPPT loop sampling array V and I,
// stepping the converter duty toward higher power, and driving the PWM gate.
// Ports: clk, rst_n (async active-low), mppt_en (run level), adc_data/adc_valid
// (sample in), adc_enable/adc_chan (conversion request), duty (committed duty),
// pwm_out (gate), busy (not IDLE), adc_err (one-cycle ADC timeout pulse).
module mppt_po_controller
    import mppt_po_controller_pkg::*;
#(
    parameter int DUTY_W      = DUTY_W_DEF,
    parameter int DUTY_INIT   = DUTY_INIT_DEF,
    parameter int DUTY_MIN    = DUTY_MIN_DEF,
    parameter int DUTY_MAX    = DUTY_MAX_DEF,
    parameter int STEP        = STEP_DEF,
    parameter int SETTLE_CYC  = 1000,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mppt_en,
    input  logic [15:0]       adc_data,
    input  logic              adc_valid,
    output logic              adc_enable,
    output logic              adc_chan,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm_out,
    output logic              busy,
    output logic              adc_err
);

    localparam int CNT_MAX = SETTLE_CYC > TIMEOUT_CYC ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] MIN_V  = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] HI_LIM = DUTY_W'(DUTY_MAX - STEP);
    localparam logic [DUTY_W-1:0] LO_LIM = DUTY_W'(DUTY_MIN + STEP);
    localparam logic [CNT_W-1:0]  TO_END = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  ST_END = CNT_W'(SETTLE_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [14:0]       v_q, v_d, i_q, i_d;
    logic [29:0]       power_q, power_d, prev_q, prev_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d, lt_q, lt_d, eq_q, eq_d, err_q, err_d;
    logic              dir_n, sat_hi, sat_lo;

    // Direction after the power comparison; a step that would leave the
    // clamp window saturates and reverses that direction once more.
    assign dir_n  = lt_q ? ~dir_q : dir_q;
    assign sat_hi = dir_n && duty_q > HI_LIM;
    assign sat_lo = !dir_n && duty_q < LO_LIM;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        i_d     = i_q;
        power_d = power_q;
        prev_d  = prev_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE:   state_d = mppt_en ? REQ_V : IDLE;
            REQ_V: begin
                state_d = WAIT_V;
                cnt_d   = '0;
            end
            WAIT_V: begin
                if (adc_valid) begin
                    v_d     = clamp_sample(adc_data);
                    state_d = REQ_I;
                end else if (cnt_q == TO_END) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REQ_I: begin
                state_d = WAIT_I;
                cnt_d   = '0;
            end
            WAIT_I: begin
                if (adc_valid) begin
                    i_d     = clamp_sample(adc_data);
                    state_d = CALC;
                end else if (cnt_q == TO_END) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CALC: begin
                power_d = {15'd0, v_q} * {15'd0, i_q};
                lt_d    = power_d < prev_q;
                eq_d    = power_d == prev_q;
                state_d = UPDATE;
            end
            UPDATE: begin
                if (!eq_q) begin
                    duty_d = sat_hi ? MAX_V : sat_lo ? MIN_V :
                             dir_n ? duty_q + STEP_V : duty_q - STEP_V;
                    dir_d  = (sat_hi || sat_lo) ? ~dir_n : dir_n;
                end
                prev_d  = power_q;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == ST_END) state_d = mppt_en ? REQ_V : IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            v_q     <= '0;
            i_q     <= '0;
            power_q <= '0;
            prev_q  <= '0;
            duty_q  <= DUTY_W'(DUTY_INIT);
            dir_q   <= 1'b1;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            i_q     <= i_d;
            power_q <= power_d;
            prev_q  <= prev_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
        end
    end

    assign adc_enable = state_q inside {REQ_V, WAIT_V, REQ_I, WAIT_I};
    assign adc_chan   = state_q inside {REQ_I, WAIT_I};
    assign busy       = state_q != IDLE;
    assign adc_err    = err_q;
    assign duty       = duty_q;

    pwm_gen #(.DUTY_W(DUTY_W), .DUTY_INIT(DUTY_INIT)) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty_i (duty_q),
        .pwm_o  (pwm_out)
    );

endmodule

// File: tb/tb_mppt_po_controller.sv
// tb_mppt_po_controller: directed bench with a P&O behavioural model and a per-cycle compare.
module tb_mppt_po_controller;

    localparam int SETTLE = 20;

    logic        clk = 1'b0, rst_n = 1'b1, mppt_en = 1'b0, adc_valid = 1'b0;
    logic [15:0] adc_data = '0;
    logic        adc_enable, adc_chan, pwm_out, busy, adc_err;
    logic [9:0]  duty;

    mppt_po_controller #(.SETTLE_CYC(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mppt_en    (mppt_en),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .adc_enable (adc_enable),
        .adc_chan   (adc_chan),
        .duty       (duty),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .adc_err    (adc_err)
    );

    always #5 clk = ~clk;

    int     n_tests = 0, n_fail = 0, err_cycles = 0;
    int     exp_duty = 512, m_dir = 1, m_cnt = 0, m_act = 512;
    longint m_prev = 0;
    bit     m_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // P&O rule applied to one (V, I) pair at the level of plain integers.
    function automatic void model_step(input logic [15:0] vr, input logic [15:0] ir);
        longint v = vr[15] ? 0 : longint'(vr[14:0]);
        longint i = ir[15] ? 0 : longint'(ir[14:0]);
        longint p = v * i;
        int nd;
        if (p != m_prev) begin
            if (p < m_prev) m_dir = 1 - m_dir;
            nd = exp_duty + (m_dir == 1 ? 4 : -4);
            if (nd > 960) begin nd = 960; m_dir = 1 - m_dir; end
            else if (nd < 64) begin nd = 64; m_dir = 1 - m_dir; end
            exp_duty = nd;
        end
        m_prev = p;
    endfunction

    // PWM period model: 1024-cycle period, duty takes effect at the wrap.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_act = 512;
            m_ok  = 0;
        end else begin
            if (m_cnt == 1023) m_act = exp_duty;
            m_cnt = (m_cnt + 1) % 1024;
            m_ok  = 1;
        end
    end

    always @(negedge clk) begin
        chk("duty", duty, exp_duty);
        if (!rst_n) begin
            chk("rst_pwm", pwm_out, 0);
            chk("rst_adc_enable", adc_enable, 0);
            chk("rst_busy", busy, 0);
            chk("rst_adc_err", adc_err, 0);
        end else begin
            if (m_ok) chk("pwm", pwm_out, m_cnt < m_act);
            if (adc_err) err_cycles++;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_duty = 512;
        m_dir    = 1;
        m_prev   = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_v_req();
        int n = 0;
        @(negedge clk);
        while (!(adc_enable && !adc_chan) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("v_request_seen", adc_enable && !adc_chan, 1);
    endtask

    task automatic do_sample(input logic [15:0] v, input logic [15:0] i, input bit stray);
        wait_v_req();
        if (stray) begin
            adc_valid = 1'b1;
            adc_data  = 16'h7FFF;
        end
        @(negedge clk);
        adc_valid = 1'b1;
        adc_data  = v;
        @(negedge clk);
        adc_valid = 1'b0;
        chk("i_req_enable", adc_enable, 1);
        chk("i_req_chan", adc_chan, 1);
        @(negedge clk);
        adc_valid = 1'b1;
        adc_data  = i;
        @(posedge clk);
        @(negedge clk);
        adc_valid = 1'b0;
        chk("calc_enable_low", adc_enable, 0);
        chk("calc_busy", busy, 1);
        @(posedge clk);
        @(posedge clk);
        #1 model_step(v, i);
    endtask

    task automatic sample_lit(input logic [15:0] v, input logic [15:0] i, input int lit, input string name);
        do_sample(v, i, 1'b0);
        chk(name, duty, lit);
        chk({"model_", name}, exp_duty, lit);
    endtask

    initial begin
        #200_0000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, hi;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        chk("reset_duty", duty, 512);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // rising power keeps dir=1
        mppt_en = 1'b1;
        sample_lit(16'd1000, 16'd1000, 516, "rise1");
        do_sample(16'd1000, 16'd1100, 1'b1);
        chk("rise2", duty, 520);
        sample_lit(16'd1000, 16'd1200, 524, "rise3");

        // falling power reverses, negative and equal samples
        do_reset();
        sample_lit(16'd1000, 16'd1000, 516, "fall_pre");
        sample_lit(16'd1000, 16'd900, 512, "fall");
        sample_lit(16'h8000, 16'd500, 516, "negative");
        sample_lit(16'hFFFF, 16'd123, 516, "equal_hold");
        sample_lit(16'd1000, 16'd100, 520, "up_again");
        sample_lit(16'd1000, 16'd50, 516, "down_again");
        for (int k = 51; k <= 115; k++) do_sample(16'd1000, 16'(k), k[0]);
        mppt_en = 1'b0;
        chk("walk_down", duty, 256);

        // new duty only after the wrap, then 256 of 1024 cycles high
        n = 0;
        @(negedge clk);
        while (m_cnt != 0 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("pwm_wrap_seen", m_cnt, 0);
        hi = 0;
        for (int k = 0; k < 1024; k++) begin
            if (k != 0) @(negedge clk);
            hi += int'(pwm_out);
        end
        chk("pwm_high_cycles", hi, 256);
        chk("idle_after_disable", busy, 0);

        // ADC timeout on the current channel
        mppt_en = 1'b1;
        wait_v_req();
        @(negedge clk);
        adc_valid = 1'b1;
        adc_data  = 16'd1000;
        @(negedge clk);
        adc_valid = 1'b0;
        mppt_en   = 1'b0;
        chk("to_i_req", adc_chan, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_err && n < 70000);
        chk("timeout_cycles", n, 65536);
        chk("timeout_busy", busy, 0);
        chk("timeout_enable", adc_enable, 0);
        @(negedge clk);
        chk("timeout_err_one_cycle", adc_err, 0);
        adc_valid = 1'b1;
        adc_data  = 16'h7FFF;
        @(negedge clk);
        adc_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("stray_valid_idle", busy, 0);
        chk("err_pulses", err_cycles, 1);

        // prev_power survived the timeout: 100000 < 115000 flips dir to 1
        mppt_en = 1'b1;
        sample_lit(16'd1000, 16'd100, 260, "after_timeout");

        // reset mid-conversion restarts from REQ_V
        wait_v_req();
        @(negedge clk);
        do_reset();
        @(posedge clk);
        @(negedge clk);
        chk("restart_enable", adc_enable, 1);
        chk("restart_chan", adc_chan, 0);

        // saturation at DUTY_MAX
        for (int k = 0; k <= 110; k++) do_sample(16'd1000, 16'(1000 + k), 1'b0);
        chk("sat_pre", duty, 956);
        sample_lit(16'd1000, 16'd1111, 960, "sat_reach");
        sample_lit(16'd1000, 16'd1112, 960, "sat_hold");
        sample_lit(16'd1000, 16'd1113, 956, "sat_back");
        mppt_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mppt_po_controller.md
MPPT_PO_CONTROLLER -- requirements
Module: mppt_po_controller

Interface
REQ-001 Parameter DUTY_W, 10, duty and PWM counter width.
REQ-002 Parameter DUTY_INIT, 512, duty after reset.
REQ-003 Parameter DUTY_MIN / DUTY_MAX, 64 / 960, duty clamp limits.
REQ-004 Parameter STEP, 4, perturbation step in duty LSBs.
REQ-005 Parameter SETTLE_CYC, 1000, clk cycles to wait after a duty change.
REQ-006 Parameter TIMEOUT_CYC, 65535, maximum clk cycles to wait for adc_valid.
REQ-007 The interface SHALL be:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- mppt_en  in  1  level; tracking runs while high.
- adc_data  in  16  two's-complement ADC sample.
- adc_valid  in  1  one-cycle pulse; adc_data valid.
- adc_enable  out  1  conversion request to the ADC reader.
- adc_chan  out  1  0 = array voltage, 1 = array current.
- duty  out  DUTY_W  committed duty.
- pwm_out  out  1  converter gate drive.
- busy  out  1  high in every state except IDLE.
- adc_err  out  1  one-cycle pulse on timeout.

Function
REQ-008 The FSM SHALL use states IDLE, REQ_V, WAIT_V, REQ_I, WAIT_I, CALC, UPDATE, SETTLE.
REQ-009 IDLE -> REQ_V when mppt_en=1; otherwise remain in IDLE.
REQ-010 In REQ_V and REQ_I, adc_enable SHALL be 1 and adc_chan SHALL be 0 or 1 respectively; the next state is WAIT_V or WAIT_I.
REQ-011 adc_enable SHALL stay high through the WAIT state until adc_valid, then drop low on the following cycle.
REQ-012 adc_valid outside a WAIT state SHALL be ignored.
REQ-013 Captured samples with bit 15 = 1 SHALL be clamped to 0; otherwise bits 14:0 are used unsigned.
REQ-014 CALC SHALL compute power = v*i as an unsigned 30-bit value in one cycle, and compare it with prev_power.
REQ-015 UPDATE SHALL apply the following rules:
- power > prev_power: keep dir.
- power < prev_power: invert dir.
- power == prev_power: hold duty and dir.
- Otherwise step duty by +STEP (dir=1) or -STEP (dir=0).
- Latch prev_power <= power.
REQ-016 A step crossing DUTY_MAX or DUTY_MIN SHALL saturate at that limit and invert dir.
REQ-017 SETTLE SHALL count SETTLE_CYC cycles, then go to REQ_V if mppt_en=1, else IDLE.
REQ-018 If adc_valid does not arrive within TIMEOUT_CYC cycles of entering a WAIT state:
- adc_err pulses for one cycle.
- adc_enable drops.
- The FSM returns to IDLE.
- duty and prev_power are unchanged.
REQ-019 Deasserting mppt_en SHALL take effect only in IDLE or at the end of SETTLE; a cycle in progress completes.
REQ-020 pwm_out SHALL be 1 while the free-running DUTY_W-bit counter < the active duty.
- The counter wraps from 2^DUTY_W-1 to 0.
- duty loads into the active register only at the wrap, so no mid-period glitch occurs.
REQ-021 duty SHALL change only in UPDATE, with one-cycle latency from CALC.

Reset
REQ-022 On rst_n low, asynchronously set:
- State IDLE.
- duty = DUTY_INIT; active PWM duty = DUTY_INIT.
- dir = 1; prev_power = 0.
- pwm_out, adc_enable, adc_chan, busy, adc_err = 0.
- All counters = 0.
REQ-023 Reset mid-conversion SHALL abandon the cycle; the first cycle after release starts from REQ_V when mppt_en=1.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding and the default DUTY_* / STEP constants.
REQ-025 PWM generation SHALL be a sub-module pwm_gen (counter, shadow duty register, compare).

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset: rst_n=0 -> duty=512, pwm_out=0, adc_enable=0, busy=0.
- Rising power: samples (V=1000, I=1000) then (1000, 1100) -> duty 512->516->520; dir stays 1.
- Falling power: after 516, samples giving a lower power -> dir=0, duty 516->512.
- Saturation: continuously rising power from duty 956 -> duty 960, then held at 960 with dir=0; the next falling step gives 956.
- Negative sample: adc_data=0x8000 -> clamped to 0, power=0; on prev_power>0, dir inverts.
- Timeout: withhold adc_valid for 65535 cycles -> one adc_err pulse, state IDLE, duty unchanged.
- PWM: duty=256 committed mid-period -> takes effect after the wrap; pwm_out high 256 of every 1024 cycles.
